// File: rtl/el2_pkg.sv
// ============================================================================
// Module   : el2_pkg
// Purpose  : Shared types and constants for the ICCM scrub controller.
// Contents : el2_iccm_scrub_state_e - scrubber FSM state encoding
//            ICCM_SCRUB_WR_SIZE     - access size used by every scrub access
//            ICCM_SCRUB_ADDR_STEP   - pointer step per line, in [*:1] units
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package el2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        SCRUB_RD = 3'd2,
        CHECK    = 3'd3,
        SCRUB_WB = 3'd4
    } el2_iccm_scrub_state_e;

    // Full 64-bit line access.
    localparam logic [2:0] ICCM_SCRUB_WR_SIZE   = 3'b011;
    // 8 bytes expressed in half-word address units (addresses are [*:1]).
    localparam logic [2:0] ICCM_SCRUB_ADDR_STEP = 3'd4;

endpackage

`default_nettype wire

// File: rtl/el2_iccm_scrub_mux.sv
// ============================================================================
// Module   : el2_iccm_scrub_mux
// Purpose  : Combinational ICCM port mux. The primary requester always owns
//            the port when it asserts a read or write; otherwise the scrub
//            engine's access (if any) is driven. Also flags a primary write
//            that lands on the line the scrubber currently holds.
// Ports    : pri_*_i     - primary request (fetch/DMA mux)
//            scrub_*_i   - scrub engine request
//            pri_req_o   - primary owns the port this cycle
//            hazard_o    - primary write to the scrub line
//            iccm_*_o    - ICCM port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module el2_iccm_scrub_mux
    import el2_pkg::*;
#(
    parameter int ICCM_BITS = 16
) (
    input  logic                 pri_rden_i,
    input  logic                 pri_wren_i,
    input  logic [ICCM_BITS-1:1] pri_addr_i,
    input  logic [2:0]           pri_wr_size_i,
    input  logic [77:0]          pri_wr_data_i,
    input  logic                 scrub_rden_i,
    input  logic                 scrub_wren_i,
    input  logic [ICCM_BITS-1:1] scrub_addr_i,
    input  logic [77:0]          scrub_wr_data_i,
    output logic                 pri_req_o,
    output logic                 hazard_o,
    output logic                 iccm_rden_o,
    output logic                 iccm_wren_o,
    output logic [ICCM_BITS-1:1] iccm_rw_addr_o,
    output logic [2:0]           iccm_wr_size_o,
    output logic [77:0]          iccm_wr_data_o
);

    assign pri_req_o = pri_rden_i | pri_wren_i;

    // Line compare ignores addr[2:1]: any write inside the 8-byte line
    // makes a held corrected copy stale.
    assign hazard_o = pri_wren_i &&
                      (pri_addr_i[ICCM_BITS-1:3] == scrub_addr_i[ICCM_BITS-1:3]);

    always_comb begin
        iccm_rden_o    = 1'b0;
        iccm_wren_o    = 1'b0;
        iccm_rw_addr_o = '0;
        iccm_wr_size_o = '0;
        iccm_wr_data_o = '0;
        if (pri_req_o) begin
            iccm_rden_o    = pri_rden_i;
            iccm_wren_o    = pri_wren_i;
            iccm_rw_addr_o = pri_addr_i;
            iccm_wr_size_o = pri_wr_size_i;
            iccm_wr_data_o = pri_wr_data_i;
        end else if (scrub_rden_i || scrub_wren_i) begin
            iccm_rden_o    = scrub_rden_i;
            iccm_wren_o    = scrub_wren_i;
            iccm_rw_addr_o = scrub_addr_i;
            iccm_wr_size_o = ICCM_SCRUB_WR_SIZE;
            iccm_wr_data_o = scrub_wren_i ? scrub_wr_data_i : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/el2_ifu_iccm_scrub_ctrl.sv
// ============================================================================
// Module   : el2_ifu_iccm_scrub_ctrl
// Purpose  : Background ECC scrubber and arbiter for the ICCM port. Walks
//            every 64-bit line in idle cycles, reads it, checks the external
//            ECC result one cycle later and writes back corrected data on
//            single-bit errors. The primary requester always wins the port.
// Ports    : clk/rst          - clock, async active-high reset
//            scrub_en/interval- enable and idle cycles between scrub reads
//            pri_*            - primary request
//            iccm_*           - ICCM port
//            ecc_*            - checker result for last cycle's read
//            scrub_busy/db_*/pass_done/sb_count - status
// Config   : RV_ICCM_SCRUB_STATS_EN - when defined, scrub_sb_count is a
//            16-bit saturating count of corrected lines; otherwise tied 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module el2_ifu_iccm_scrub_ctrl
    import el2_pkg::*;
#(
    parameter int ICCM_BITS  = 16,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scrub_en,
    input  logic [INTERVAL_W-1:0] scrub_interval,
    input  logic                  pri_rden,
    input  logic                  pri_wren,
    input  logic [ICCM_BITS-1:1]  pri_addr,
    input  logic [2:0]            pri_wr_size,
    input  logic [77:0]           pri_wr_data,
    output logic                  iccm_rden,
    output logic                  iccm_wren,
    output logic [ICCM_BITS-1:1]  iccm_rw_addr,
    output logic [2:0]            iccm_wr_size,
    output logic [77:0]           iccm_wr_data,
    input  logic                  ecc_sb_err,
    input  logic                  ecc_db_err,
    input  logic [77:0]           ecc_corr_data,
    output logic                  scrub_busy,
    output logic                  scrub_db_pulse,
    output logic [ICCM_BITS-1:1]  scrub_db_addr,
    output logic                  scrub_pass_done,
    output logic [15:0]           scrub_sb_count
);

    localparam int AW = ICCM_BITS - 1;

    el2_iccm_scrub_state_e state_q, state_d;

    logic [ICCM_BITS-1:1]  ptr_q;
    logic [INTERVAL_W-1:0] cnt_q;
    logic [77:0]           hold_q;
    logic [ICCM_BITS-1:1]  db_addr_q;

    logic pri_req, hazard;
    logic scrub_rd, scrub_wr, advance, capture, load_cnt, dec_cnt, cnt_inc;

    el2_iccm_scrub_mux #(.ICCM_BITS(ICCM_BITS)) u_mux (
        .pri_rden_i      (pri_rden),
        .pri_wren_i      (pri_wren),
        .pri_addr_i      (pri_addr),
        .pri_wr_size_i   (pri_wr_size),
        .pri_wr_data_i   (pri_wr_data),
        .scrub_rden_i    (scrub_rd),
        .scrub_wren_i    (scrub_wr),
        .scrub_addr_i    (ptr_q),
        .scrub_wr_data_i (hold_q),
        .pri_req_o       (pri_req),
        .hazard_o        (hazard),
        .iccm_rden_o     (iccm_rden),
        .iccm_wren_o     (iccm_wren),
        .iccm_rw_addr_o  (iccm_rw_addr),
        .iccm_wr_size_o  (iccm_wr_size),
        .iccm_wr_data_o  (iccm_wr_data)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (scrub_en) state_d = WAIT;
            WAIT: begin
                if (!scrub_en)
                    state_d = IDLE;
                // The idle cycle that drains the counter to zero is the last
                // one needed, so the read follows directly.
                else if ((cnt_q == '0) || ((cnt_q == INTERVAL_W'(1)) && !pri_req))
                    state_d = SCRUB_RD;
            end
            SCRUB_RD: begin
                if (!scrub_en)     state_d = IDLE;
                else if (!pri_req) state_d = CHECK;
            end
            CHECK: begin
                if (hazard)                         state_d = scrub_en ? SCRUB_RD : IDLE;
                else if (ecc_db_err || !ecc_sb_err) state_d = scrub_en ? WAIT : IDLE;
                else                                state_d = SCRUB_WB;
            end
            SCRUB_WB: begin
                if (hazard)        state_d = scrub_en ? SCRUB_RD : IDLE;
                else if (!pri_req) state_d = scrub_en ? WAIT : IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath control ----------------
    always_comb begin
        scrub_rd       = 1'b0;
        scrub_wr       = 1'b0;
        advance        = 1'b0;
        capture        = 1'b0;
        load_cnt       = 1'b0;
        dec_cnt        = 1'b0;
        cnt_inc        = 1'b0;
        scrub_db_pulse = 1'b0;
        case (state_q)
            IDLE:     load_cnt = scrub_en;
            WAIT:     dec_cnt  = scrub_en && !pri_req;
            SCRUB_RD: begin
                if (scrub_en && !pri_req) begin
                    scrub_rd = 1'b1;
                    load_cnt = 1'b1;
                end
            end
            CHECK: begin
                // The check cycle itself counts as an idle gap cycle.
                dec_cnt = !pri_req;
                if (!hazard) begin
                    if (ecc_db_err) begin
                        scrub_db_pulse = 1'b1;
                        advance        = 1'b1;
                    end else if (ecc_sb_err) begin
                        capture = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            SCRUB_WB: begin
                // A hazard implies a primary write, so no write-back issues.
                if (!pri_req) begin
                    scrub_wr = 1'b1;
                    advance  = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign scrub_busy      = (state_q == SCRUB_RD) || (state_q == CHECK) || (state_q == SCRUB_WB);
    assign scrub_pass_done = advance && (ptr_q[ICCM_BITS-1:3] == '1);
    assign scrub_db_addr   = db_addr_q;

    // ---------------- pointer, interval counter, holding registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            db_addr_q <= '0;
        end else begin
            if (advance)
                ptr_q <= ptr_q + AW'(ICCM_SCRUB_ADDR_STEP);
            if (load_cnt)
                cnt_q <= scrub_interval;
            else if (dec_cnt && (cnt_q != '0))
                cnt_q <= cnt_q - INTERVAL_W'(1);
            if (capture)
                hold_q <= ecc_corr_data;
            if (scrub_db_pulse)
                db_addr_q <= ptr_q;
        end
    end

`ifdef RV_ICCM_SCRUB_STATS_EN
    logic [15:0] sb_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_cnt_q <= '0;
        else if (cnt_inc && (sb_cnt_q != 16'hFFFF))
            sb_cnt_q <= sb_cnt_q + 16'd1;
    end

    assign scrub_sb_count = sb_cnt_q;
`else
    logic cnt_inc_unused;
    assign cnt_inc_unused = cnt_inc;
    assign scrub_sb_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_el2_ifu_iccm_scrub_ctrl.sv
`default_nettype none

module tb_el2_ifu_iccm_scrub_ctrl;

    localparam int IB = 6;
`ifdef RV_ICCM_SCRUB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        scrub_en;
    logic [15:0] scrub_interval;
    logic        pri_rden, pri_wren;
    logic [IB-1:1] pri_addr;
    logic [2:0]  pri_wr_size;
    logic [77:0] pri_wr_data;
    logic        iccm_rden, iccm_wren;
    logic [IB-1:1] iccm_rw_addr;
    logic [2:0]  iccm_wr_size;
    logic [77:0] iccm_wr_data;
    logic        ecc_sb_err, ecc_db_err;
    logic [77:0] ecc_corr_data;
    logic        scrub_busy, scrub_db_pulse, scrub_pass_done;
    logic [IB-1:1] scrub_db_addr;
    logic [15:0] scrub_sb_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    el2_ifu_iccm_scrub_ctrl #(.ICCM_BITS(IB), .INTERVAL_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .scrub_en        (scrub_en),
        .scrub_interval  (scrub_interval),
        .pri_rden        (pri_rden),
        .pri_wren        (pri_wren),
        .pri_addr        (pri_addr),
        .pri_wr_size     (pri_wr_size),
        .pri_wr_data     (pri_wr_data),
        .iccm_rden       (iccm_rden),
        .iccm_wren       (iccm_wren),
        .iccm_rw_addr    (iccm_rw_addr),
        .iccm_wr_size    (iccm_wr_size),
        .iccm_wr_data    (iccm_wr_data),
        .ecc_sb_err      (ecc_sb_err),
        .ecc_db_err      (ecc_db_err),
        .ecc_corr_data   (ecc_corr_data),
        .scrub_busy      (scrub_busy),
        .scrub_db_pulse  (scrub_db_pulse),
        .scrub_db_addr   (scrub_db_addr),
        .scrub_pass_done (scrub_pass_done),
        .scrub_sb_count  (scrub_sb_count)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"},  80'(iccm_rden),       80'd0);
        chk({tag, "_wren"},  80'(iccm_wren),       80'd0);
        chk({tag, "_addr"},  80'(iccm_rw_addr),    80'd0);
        chk({tag, "_size"},  80'(iccm_wr_size),    80'd0);
        chk({tag, "_data"},  80'(iccm_wr_data),    80'd0);
        chk({tag, "_busy"},  80'(scrub_busy),      80'd0);
        chk({tag, "_dbp"},   80'(scrub_db_pulse),  80'd0);
        chk({tag, "_dba"},   80'(scrub_db_addr),   80'd0);
        chk({tag, "_pass"},  80'(scrub_pass_done), 80'd0);
        chk({tag, "_cnt"},   80'(scrub_sb_count),  80'd0);
    endtask

    // Clean line: RD cycle, CHECK cycle (no error), one WAIT cycle.
    task automatic clean_line(input int addr, input bit last);
        step(); #1;
        chk($sformatf("rd%0d_rden", addr), 80'(iccm_rden),    80'd1);
        chk($sformatf("rd%0d_addr", addr), 80'(iccm_rw_addr), 80'(addr));
        chk($sformatf("rd%0d_size", addr), 80'(iccm_wr_size), 80'd3);
        chk($sformatf("rd%0d_wren", addr), 80'(iccm_wren),    80'd0);
        chk($sformatf("rd%0d_busy", addr), 80'(scrub_busy),   80'd1);
        step(); #1;
        chk($sformatf("ck%0d_rden", addr), 80'(iccm_rden),       80'd0);
        chk($sformatf("ck%0d_wren", addr), 80'(iccm_wren),       80'd0);
        chk($sformatf("ck%0d_pass", addr), 80'(scrub_pass_done), 80'(last));
        step(); #1;
        chk($sformatf("wt%0d_rden", addr), 80'(iccm_rden),  80'd0);
        chk($sformatf("wt%0d_busy", addr), 80'(scrub_busy), 80'd0);
        chk($sformatf("wt%0d_pass", addr), 80'(scrub_pass_done), 80'd0);
    endtask

    initial begin
        rst = 1'b1; scrub_en = 1'b0; scrub_interval = '0;
        pri_rden = 1'b0; pri_wren = 1'b0; pri_addr = '0;
        pri_wr_size = '0; pri_wr_data = '0;
        ecc_sb_err = 1'b0; ecc_db_err = 1'b0; ecc_corr_data = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");

        // ---- enable, interval 2: IDLE, WAIT, WAIT, then first read ----
        step();
        rst = 1'b0; scrub_en = 1'b1; scrub_interval = 16'd2;
        #1; chk("c0_rden", 80'(iccm_rden), 80'd0);
        step(); #1; chk("c1_rden", 80'(iccm_rden), 80'd0);
        step(); #1; chk("c2_rden", 80'(iccm_rden), 80'd0);

        // ---- full pass 0..28, reads every 3 cycles, wrap pulse after 28 ----
        for (int i = 0; i < 8; i++) clean_line(4 * i, i == 7);
        clean_line(0, 1'b0);
        clean_line(4, 1'b0);

        // ---- single-bit error on line 8 ----
        step(); #1;
        chk("sb_rd_rden", 80'(iccm_rden), 80'd1);
        chk("sb_rd_addr", 80'(iccm_rw_addr), 80'd8);
        step();
        ecc_sb_err = 1'b1; ecc_corr_data = 78'h1234;
        #1;
        chk("sb_ck_wren", 80'(iccm_wren), 80'd0);
        chk("sb_ck_dbp",  80'(scrub_db_pulse), 80'd0);
        step();
        ecc_sb_err = 1'b0; ecc_corr_data = '0;
        #1;
        chk("sb_wb_wren", 80'(iccm_wren),    80'd1);
        chk("sb_wb_rden", 80'(iccm_rden),    80'd0);
        chk("sb_wb_addr", 80'(iccm_rw_addr), 80'd8);
        chk("sb_wb_size", 80'(iccm_wr_size), 80'd3);
        chk("sb_wb_data", 80'(iccm_wr_data), 80'h1234);
        chk("sb_wb_cnt0", 80'(scrub_sb_count), 80'd0);
        step(); #1;
        chk("sb_after_wren", 80'(iccm_wren), 80'd0);
        chk("sb_after_cnt",  80'(scrub_sb_count), 80'(STATS));

        // ---- double-bit (with single-bit) error on line 12 ----
        step(); #1;
        chk("db_rd_rden", 80'(iccm_rden), 80'd1);
        chk("db_rd_addr", 80'(iccm_rw_addr), 80'd12);
        step();
        ecc_sb_err = 1'b1; ecc_db_err = 1'b1; ecc_corr_data = 78'h9999;
        #1;
        chk("db_ck_pulse", 80'(scrub_db_pulse), 80'd1);
        chk("db_ck_wren",  80'(iccm_wren), 80'd0);
        step();
        ecc_sb_err = 1'b0; ecc_db_err = 1'b0; ecc_corr_data = '0;
        #1;
        chk("db_nx_pulse", 80'(scrub_db_pulse), 80'd0);
        chk("db_nx_addr",  80'(scrub_db_addr), 80'd12);
        chk("db_nx_wren",  80'(iccm_wren), 80'd0);
        chk("db_nx_cnt",   80'(scrub_sb_count), 80'(STATS));

        // ---- contention: primary reads for 10 cycles during write-back ----
        step(); #1;
        chk("ct_rd_addr", 80'(iccm_rw_addr), 80'd16);
        step();
        ecc_sb_err = 1'b1; ecc_corr_data = 78'hABCD;
        #1;
        step();
        ecc_sb_err = 1'b0; ecc_corr_data = '0;
        pri_rden = 1'b1; pri_addr = 5'd5; pri_wr_size = 3'b101;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("ct%0d_rden", k), 80'(iccm_rden),    80'd1);
            chk($sformatf("ct%0d_wren", k), 80'(iccm_wren),    80'd0);
            chk($sformatf("ct%0d_addr", k), 80'(iccm_rw_addr), 80'd5);
            chk($sformatf("ct%0d_size", k), 80'(iccm_wr_size), 80'd5);
            step(); #1;
        end
        pri_rden = 1'b0; pri_addr = '0; pri_wr_size = '0;
        #1;
        chk("ct_wb_wren", 80'(iccm_wren),    80'd1);
        chk("ct_wb_addr", 80'(iccm_rw_addr), 80'd16);
        chk("ct_wb_data", 80'(iccm_wr_data), 80'hABCD);
        step(); #1;
        chk("ct_after_cnt", 80'(scrub_sb_count), 80'(2 * STATS));

        // ---- stale write-back: primary write to 22 hits held line 20 ----
        step(); #1;
        chk("st_rd_addr", 80'(iccm_rw_addr), 80'd20);
        step();
        ecc_sb_err = 1'b1; ecc_corr_data = 78'h5555;
        #1;
        step();
        ecc_sb_err = 1'b0; ecc_corr_data = '0;
        pri_wren = 1'b1; pri_addr = 5'd22; pri_wr_size = 3'b010; pri_wr_data = 78'h77;
        #1;
        chk("st_wb_wren", 80'(iccm_wren),    80'd1);
        chk("st_wb_addr", 80'(iccm_rw_addr), 80'd22);
        chk("st_wb_data", 80'(iccm_wr_data), 80'h77);
        step();
        pri_wren = 1'b0; pri_addr = '0; pri_wr_size = '0; pri_wr_data = '0;
        #1;
        chk("st_rerd_rden", 80'(iccm_rden),    80'd1);
        chk("st_rerd_addr", 80'(iccm_rw_addr), 80'd20);
        chk("st_rerd_wren", 80'(iccm_wren),    80'd0);
        step(); #1;
        chk("st_ck_wren", 80'(iccm_wren), 80'd0);
        chk("st_ck_cnt",  80'(scrub_sb_count), 80'(2 * STATS));
        step(); #1;
        chk("st_wt_wren", 80'(iccm_wren), 80'd0);
        step(); #1;
        chk("st_next_addr", 80'(iccm_rw_addr), 80'd24);
        chk("st_next_rden", 80'(iccm_rden), 80'd1);

        // ---- disable in WAIT, pointer retained ----
        step(); #1;
        step();
        scrub_en = 1'b0;
        #1;
        chk("dis_wt_rden", 80'(iccm_rden), 80'd0);
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            chk($sformatf("dis%0d_rden", k), 80'(iccm_rden),  80'd0);
            chk($sformatf("dis%0d_busy", k), 80'(scrub_busy), 80'd0);
        end
        step();
        scrub_en = 1'b1; scrub_interval = 16'd0;
        #1;
        chk("ren_idle_rden", 80'(iccm_rden), 80'd0);
        step(); #1;
        chk("ren_wait_rden", 80'(iccm_rden), 80'd0);
        step(); #1;
        chk("ren_rd_rden", 80'(iccm_rden),    80'd1);
        chk("ren_rd_addr", 80'(iccm_rw_addr), 80'd28);

        // ---- reset in CHECK with a pending single-bit error ----
        step();
        ecc_sb_err = 1'b1; ecc_corr_data = 78'h42; rst = 1'b1;
        #1;
        chk_all_zero("rst_ck");
        step();
        ecc_sb_err = 1'b0; ecc_corr_data = '0;
        #1;
        chk_all_zero("rst_hold");
        rst = 1'b0;
        #1;
        chk("post_idle_rden", 80'(iccm_rden), 80'd0);
        step(); #1;
        chk("post_wait_wren", 80'(iccm_wren), 80'd0);
        chk("post_wait_rden", 80'(iccm_rden), 80'd0);
        step(); #1;
        chk("post_rd_rden", 80'(iccm_rden),    80'd1);
        chk("post_rd_addr", 80'(iccm_rw_addr), 80'd0);
        chk("post_rd_wren", 80'(iccm_wren),    80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/el2_ifu_iccm_scrub_ctrl.md
Name: el2_ifu_iccm_scrub_ctrl

Overview:
- Background ECC scrubber and access arbiter in front of the ICCM read/write port.
- Shares the single ICCM port between the primary requester and an internal scrub engine. The primary requester is the IFU fetch/DMA mux.
- The scrub engine walks every 64-bit line. It reads the line, samples the external ECC checker result, and writes back corrected data on single-bit errors.
- The primary requester always wins. The scrubber only uses idle cycles.

Parameters:
- ICCM_BITS, 16: byte-address width of the ICCM. Addresses are carried as [ICCM_BITS-1:1].
- INTERVAL_W, 16: width of the idle-interval counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- scrub_en  in  1  enables scrubbing. Deassertion aborts at the next safe point.
- scrub_interval  in  INTERVAL_W  idle cycles required between scrub reads.
- pri_rden  in  1  primary read request.
- pri_wren  in  1  primary write request.
- pri_addr  in  ICCM_BITS-1  primary address [ICCM_BITS-1:1].
- pri_wr_size  in  3  primary write size.
- pri_wr_data  in  78  primary write data, 2x39 with ECC.
- iccm_rden  out  1  ICCM read strobe.
- iccm_wren  out  1  ICCM write strobe.
- iccm_rw_addr  out  ICCM_BITS-1  ICCM address.
- iccm_wr_size  out  3  ICCM write size.
- iccm_wr_data  out  78  ICCM write data.
- ecc_sb_err  in  1  single-bit error on the read issued last cycle.
- ecc_db_err  in  1  double-bit error on the read issued last cycle.
- ecc_corr_data  in  78  corrected data plus regenerated ECC, valid alongside ecc_*_err.
- scrub_busy  out  1  scrubber holds a line in flight (SCRUB_RD..SCRUB_WB).
- scrub_db_pulse  out  1  one-cycle pulse on an uncorrectable error.
- scrub_db_addr  out  ICCM_BITS-1  address of the last uncorrectable line.
- scrub_pass_done  out  1  one-cycle pulse when the address pointer wraps.
- scrub_sb_count  out  16  corrected-line counter (optional feature).

Behaviour:
- Reset values:
  - all outputs 0;
  - address pointer 0;
  - interval counter 0;
  - FSM in IDLE.
- Arbitration:
  - When pri_rden or pri_wren is high, iccm_* is a combinational pass-through of pri_*, zero added latency.
  - The scrubber drives iccm_* only in cycles with no primary request.
- ICCM read data returns 1 cycle after iccm_rden. The ecc_* inputs are sampled in that cycle.
- Scrub accesses:
  - always a full 64-bit line;
  - addr[2:1] = 0;
  - iccm_wr_size = 3'b011;
  - the pointer increments by 4 (8 bytes);
  - the pointer wraps from its all-ones line to 0 and pulses scrub_pass_done in the same cycle.
- FSM:
  - IDLE: when scrub_en=1, load the interval counter with scrub_interval and go to WAIT.
  - WAIT:
    - The counter decrements on cycles with no primary request and holds otherwise.
    - At 0 go to SCRUB_RD.
    - scrub_interval=0 means go to SCRUB_RD immediately.
  - SCRUB_RD:
    - Assert iccm_rden with the pointer in the first cycle with no primary request; go to CHECK.
    - Primary traffic stalls this state indefinitely.
  - CHECK:
    - No error: advance the pointer, go to WAIT.
    - ecc_db_err (takes priority if both error flags are set):
      - pulse scrub_db_pulse;
      - latch scrub_db_addr;
      - advance the pointer, no write-back, go to WAIT.
    - ecc_sb_err: capture ecc_corr_data into the holding register, go to SCRUB_WB.
  - SCRUB_WB:
    - In the first cycle with no primary request, assert iccm_wren with the holding data.
    - Then increment scrub_sb_count, advance the pointer and go to WAIT.
- Hazards:
  - A primary write to the same line (pri_addr[ICCM_BITS-1:3] == pointer line) while in CHECK or SCRUB_WB drops the pending write-back. The corrected copy is stale.
  - In that case go to SCRUB_RD on the same line; no count, no pointer advance.
  - A primary write in the same cycle as CHECK is also a hit.
- scrub_en=0:
  - In WAIT or SCRUB_RD: go to IDLE next cycle.
  - In CHECK or SCRUB_WB: complete the line, then go to IDLE.
- The pointer is retained across scrub_en toggles. Only rst clears it.
- scrub_sb_count saturates at 16'hFFFF.
- Reset mid-operation abandons any pending write-back.

Optional Feature:
- Macro RV_ICCM_SCRUB_STATS_EN.
- Defined: the 16-bit saturating scrub_sb_count register exists as specified.
- Undefined:
  - no counter flops;
  - scrub_sb_count tied to 0;
  - all other behaviour unchanged.

Decomposition:
- The shared package el2_pkg holds:
  - typedef el2_iccm_scrub_state_e (IDLE, WAIT, SCRUB_RD, CHECK, SCRUB_WB);
  - constant ICCM_SCRUB_WR_SIZE = 3'b011;
  - constant ICCM_SCRUB_ADDR_STEP = 4.
- One sub-module, el2_iccm_scrub_mux: the combinational primary/scrub port mux and same-line hazard compare.
- FSM and counters stay in the top module.

Test Plan:
- Idle, no errors: scrub_en=1, scrub_interval=2, ICCM_BITS=6.
  - Required: reads at addr 0,4,...,28, each 3 cycles apart.
  - Required: scrub_pass_done pulses after addr 28; iccm_wren never asserted.
- Single-bit error: ecc_sb_err=1 on the read of addr 8 with ecc_corr_data=78'h1234.
  - Required: the next free cycle writes 78'h1234 to addr 8 with wr_size 3'b011; scrub_sb_count goes 0->1.
- Double-bit error: ecc_db_err=1 and ecc_sb_err=1 on addr 12.
  - Required: scrub_db_pulse for exactly 1 cycle; scrub_db_addr=12; no write; count unchanged.
- Contention: pri_rden held high for 10 cycles while in SCRUB_WB.
  - Required: iccm_* mirrors the primary each cycle; the write-back issues on cycle 11.
- Stale write-back: primary write to addr 10 (same line as pointer 8) while in SCRUB_WB.
  - Required: no scrub write; a re-read of addr 8 follows; the pointer does not advance.
- Reset and disable:
  - Assert rst in CHECK. Required: all outputs 0 and the pointer returns to 0.
  - Separately, scrub_en=0 in WAIT. Required: no further scrub reads, and the pointer is retained.
